mc_rd_arbiter: RTL

MC_RD_ARBITER -- requirements
Module: mc_rd_arbiter

---
 rtl/mc_rd_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mc_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a memory controller.
// In-order tag FIFO routes returned read data back to the issuing requester.
module mc_rd_arbiter #(
    parameter int unsigned ADDR_W  = 31,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r0_req,
    input  logic [ADDR_W-1:0]         r0_addr,
    output logic                      r0_gnt,
    output logic                      r0_rd_valid,
    output logic [DATA_W-1:0]         r0_rd_data,
    input  logic                      r1_req,
    input  logic [ADDR_W-1:0]         r1_addr,
    output logic                      r1_gnt,
    output logic                      r1_rd_valid,
    output logic [DATA_W-1:0]         r1_rd_data,
    output logic                      mc_cmd_en,
    output logic [ADDR_W-1:0]         mc_cmd_addr,
    input  logic                      mc_cmd_rdy,
    input  logic                      mc_rd_valid,
    input  logic [DATA_W-1:0]         mc_rd_data,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_unexp
);
    localparam int unsigned PTR_W = $clog2(MAX_OUT);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StCmd} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tag_q, tag_d;     // requester that owns the pending command
    logic                last_q, last_d;   // 1 = r1 granted last
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_OUT-1:0]  fifo_q;           // one tag bit per outstanding slot
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic                rdv0_q, rdv1_q;
    logic [DATA_W-1:0]   rdd0_q, rdd1_q;
    logic                err_q;

    logic transfer, pop, unexp, winner, slot_free, head_tag;

    assign transfer  = (state_q == StCmd) && mc_cmd_rdy;
    assign pop       = mc_rd_valid && (cnt_q != '0);
    assign unexp     = mc_rd_valid && (cnt_q == '0);
    assign slot_free = cnt_q < CNT_W'(MAX_OUT);
    assign winner    = r1_req && (!r0_req || !last_q);
    assign head_tag  = fifo_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((r0_req || r1_req) && slot_free) begin
                    state_d = StCmd;
                    addr_d  = winner ? r1_addr : r0_addr;
                    tag_d   = winner;
                    last_d  = winner;
                    gnt0_d  = !winner;
                    gnt1_d  = winner;
                end
            end
            StCmd: begin
                if (transfer) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (transfer && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!transfer && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            tag_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdv0_q   <= 1'b0;
            rdv1_q   <= 1'b0;
            rdd0_q   <= '0;
            rdd1_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (transfer) begin
                fifo_q[wr_ptr_q] <= tag_q;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            rdv0_q <= pop && !head_tag;
            rdv1_q <= pop && head_tag;
            if (pop && !head_tag) rdd0_q <= mc_rd_data;
            if (pop && head_tag)  rdd1_q <= mc_rd_data;
            if (unexp) err_q <= 1'b1;
        end
    end

    assign r0_gnt      = gnt0_q;
    assign r1_gnt      = gnt1_q;
    assign r0_rd_valid = rdv0_q;
    assign r1_rd_valid = rdv1_q;
    assign r0_rd_data  = rdd0_q;
    assign r1_rd_data  = rdd1_q;
    assign mc_cmd_en   = (state_q == StCmd);
    assign mc_cmd_addr = addr_q;
    assign outstanding = cnt_q;
    assign err_unexp   = err_q;

endmodule
